// File: rtl/pixmux_pkg.sv
// rtl/pixmux_pkg.sv - shared types and default constants for the pixel stream arbiter
// Contents: arbiter state enum, drop counter width, default frame size and lock timeout.

package pixmux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam int DROP_W          = 16;
    localparam int FRAME_PIX_DEF   = 291600;  // 540 x 540
    localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/pixmux_prio_enc.sv
// rtl/pixmux_prio_enc.sv - lowest-index-wins priority encoder
// Ports:
//   req_i   [N-1:0]      request vector
//   idx_o   [IDX_W-1:0]  index of the lowest set request (0 when none)
//   valid_o              at least one request is set

module pixmux_prio_enc #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_arbiter.sv
// rtl/pixel_stream_arbiter.sv - frame-locked arbiter forwarding one of NUM_CH pixel streams
// Optional feature macro: PIXMUX_TIMEOUT_EN (release the lock after TIMEOUT_CYC silent owner cycles).
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ch_pixel_i         channel k pixel at [k*PIX_W +: PIX_W]
//   ch_pixel_en_i      per-channel pixel valid
//   clear_i            clears collision flag and drop counter
//   pixel_o/pixel_en_o forwarded pixel and valid (one cycle after input)
//   owner_o            locked channel index (holds last owner while idle)
//   busy_o             a channel holds the lock
//   frame_done_o       pulses with the last pixel of a frame
//   collision_o        sticky: a non-owner channel asserted enable
//   drop_cnt_o         saturating count of dropped non-owner pixels

module pixel_stream_arbiter
    import pixmux_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int PIX_W       = 8,
    parameter int FRAME_PIX   = FRAME_PIX_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*PIX_W-1:0]   ch_pixel_i,
    input  logic [NUM_CH-1:0]         ch_pixel_en_i,
    input  logic                      clear_i,
    output logic [PIX_W-1:0]          pixel_o,
    output logic                      pixel_en_o,
    output logic [$clog2(NUM_CH)-1:0] owner_o,
    output logic                      busy_o,
    output logic                      frame_done_o,
    output logic                      collision_o,
    output logic [DROP_W-1:0]         drop_cnt_o
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int POP_W = $clog2(NUM_CH + 1);

    if (NUM_CH < 2 || NUM_CH > 8 || FRAME_PIX < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("pixel_stream_arbiter: parameter out of range");
    end

    state_e             state_q, state_d;
    logic [PIX_W-1:0]   pixel_q, pixel_d;
    logic               pixel_en_q, pixel_en_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               frame_done_q, frame_done_d;
    logic               collision_q, collision_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0]   claim_idx;
    logic               claim_valid;
    logic [IDX_W-1:0]   owner_sel;
    logic [NUM_CH-1:0]  drop_mask;
    logic [POP_W-1:0]   n_drops;
    logic [DROP_W:0]    drop_sum;
    logic               owner_en;
    logic               fwd;
    logic               frame_last;
    logic               timeout_hit;
    logic [PIX_W-1:0]   fwd_pix;

    pixmux_prio_enc #(
        .N     (NUM_CH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req_i   (ch_pixel_en_i),
        .idx_o   (claim_idx),
        .valid_o (claim_valid)
    );

    // The channel whose pixel may be forwarded this cycle: the claimant in
    // IDLE, the lock holder in LOCK. Everyone else who is enabled is a drop.
    assign owner_sel  = (state_q == IDLE) ? claim_idx : owner_q;
    assign owner_en   = ch_pixel_en_i[owner_q];
    assign fwd        = (state_q == IDLE) ? claim_valid : owner_en;
    assign fwd_pix    = ch_pixel_i[owner_sel*PIX_W +: PIX_W];
    assign drop_mask  = ch_pixel_en_i & ~(NUM_CH'(1) << owner_sel);
    // A claim is pixel 0, so it only ends a frame when frames are one pixel long.
    assign frame_last = (state_q == IDLE) ? (FRAME_PIX == 1)
                                          : (cnt_q == CNT_W'(FRAME_PIX - 1));

    always_comb begin
        n_drops = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_drops = n_drops + POP_W'(drop_mask[i]);
        end
    end

    assign drop_sum = {1'b0, drop_cnt_q} + (DROP_W + 1)'(n_drops);

`ifdef PIXMUX_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

    assign timeout_hit = (state_q == LOCK) && !owner_en &&
                         (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    // Counts consecutive silent owner cycles; any owner pixel restarts it.
    always_comb begin
        idle_cnt_d = '0;
        if (state_q == LOCK && !owner_en && !timeout_hit) begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pixel_q      <= '0;
            pixel_en_q   <= 1'b0;
            owner_q      <= '0;
            frame_done_q <= 1'b0;
            collision_q  <= 1'b0;
            drop_cnt_q   <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pixel_q      <= pixel_d;
            pixel_en_q   <= pixel_en_d;
            owner_q      <= owner_d;
            frame_done_q <= frame_done_d;
            collision_q  <= collision_d;
            drop_cnt_q   <= drop_cnt_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic. The frame-end cycle is spent in LOCK, so a new claim
    // is only looked at on the following cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (claim_valid && !frame_last) begin
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if ((owner_en && frame_last) || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        pixel_d      = pixel_q;
        pixel_en_d   = fwd;
        frame_done_d = fwd && frame_last;
        owner_d      = (state_q == IDLE && claim_valid) ? claim_idx : owner_q;
        cnt_d        = cnt_q;

        if (fwd) begin
            pixel_d = fwd_pix;
            cnt_d   = frame_last ? '0 : cnt_q + CNT_W'(1);
        end else if (timeout_hit) begin
            cnt_d   = '0;
        end

        // clear_i wins over any drop seen in the same cycle.
        if (clear_i) begin
            collision_d = 1'b0;
            drop_cnt_d  = '0;
        end else begin
            collision_d = collision_q || (n_drops != '0);
            drop_cnt_d  = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
        end
    end

    assign pixel_o      = pixel_q;
    assign pixel_en_o   = pixel_en_q;
    assign owner_o      = owner_q;
    assign busy_o       = (state_q == LOCK);
    assign frame_done_o = frame_done_q;
    assign collision_o  = collision_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_pixel_stream_arbiter.sv
// tb/tb_pixel_stream_arbiter.sv - directed vector bench for pixel_stream_arbiter

module tb_pixel_stream_arbiter;

    localparam int NUM_CH = 4;
    localparam int PIX_W  = 8;

    logic                    clk;
    logic                    rst;
    logic [NUM_CH*PIX_W-1:0] ch_pixel;
    logic [NUM_CH-1:0]       ch_en;
    logic                    clr;
    logic [PIX_W-1:0]        pixel_o;
    logic                    pixel_en_o;
    logic [1:0]              owner_o;
    logic                    busy_o;
    logic                    frame_done_o;
    logic                    collision_o;
    logic [15:0]             drop_cnt_o;

    pixel_stream_arbiter #(
        .NUM_CH      (NUM_CH),
        .PIX_W       (PIX_W),
        .FRAME_PIX   (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ch_pixel_i    (ch_pixel),
        .ch_pixel_en_i (ch_en),
        .clear_i       (clr),
        .pixel_o       (pixel_o),
        .pixel_en_o    (pixel_en_o),
        .owner_o       (owner_o),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .collision_o   (collision_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] pix;
        logic        clr;
        logic [7:0]  e_pix;
        logic        e_en;
        logic [1:0]  e_own;
        logic        e_busy;
        logic        e_fd;
        logic        e_col;
        logic [15:0] e_drop;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] px(input logic [7:0] c0, input logic [7:0] c1,
                                       input logic [7:0] c2, input logic [7:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic vec_t mk(input logic [3:0] en, input logic [31:0] pix, input logic c,
                                input logic [7:0] e_pix, input logic e_en, input logic [1:0] e_own,
                                input logic e_busy, input logic e_fd, input logic e_col,
                                input logic [15:0] e_drop);
        vec_t v;
        v.en = en; v.pix = pix; v.clr = c;
        v.e_pix = e_pix; v.e_en = e_en; v.e_own = e_own; v.e_busy = e_busy;
        v.e_fd = e_fd; v.e_col = e_col; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d got %0h expected %0h", nm, id, got, exp);
        end
    endtask

    task automatic chk_outputs(input vec_t v, input int id);
        chk("pixel_o",      id, 32'(pixel_o),      32'(v.e_pix));
        chk("pixel_en_o",   id, 32'(pixel_en_o),   32'(v.e_en));
        chk("owner_o",      id, 32'(owner_o),      32'(v.e_own));
        chk("busy_o",       id, 32'(busy_o),       32'(v.e_busy));
        chk("frame_done_o", id, 32'(frame_done_o), 32'(v.e_fd));
        chk("collision_o",  id, 32'(collision_o),  32'(v.e_col));
        chk("drop_cnt_o",   id, 32'(drop_cnt_o),   32'(v.e_drop));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked at the same offset.
    task automatic run_vec(input vec_t v, input int id);
        ch_en    = v.en;
        ch_pixel = v.pix;
        clr      = v.clr;
        @(posedge clk);
        #1;
        chk_outputs(v, id);
    endtask

    vec_t tbl[16];
    vec_t zero_v;
    vec_t v;
    bit   to_en;

    initial begin
        #2_000_000;
        $display("FAIL watchdog step 0 got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef PIXMUX_TIMEOUT_EN
        to_en = 1'b1;
`else
        to_en = 1'b0;
`endif
        zero_v = mk(4'b0000, 32'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Single-channel frame, then collisions, drops, clear and back-to-back claim.
        tbl[0]  = mk(4'b0010, px(8'h00, 8'h11, 8'h00, 8'h00), 1'b0, 8'h11, 1, 2'd1, 1, 0, 0, 16'd0);
        tbl[1]  = mk(4'b0010, px(8'h00, 8'h12, 8'h00, 8'h00), 1'b0, 8'h12, 1, 2'd1, 1, 0, 0, 16'd0);
        tbl[2]  = mk(4'b0000, px(8'h55, 8'h55, 8'h55, 8'h55), 1'b0, 8'h12, 0, 2'd1, 1, 0, 0, 16'd0);
        tbl[3]  = mk(4'b0010, px(8'h00, 8'h13, 8'h00, 8'h00), 1'b0, 8'h13, 1, 2'd1, 1, 0, 0, 16'd0);
        tbl[4]  = mk(4'b0010, px(8'h00, 8'h14, 8'h00, 8'h00), 1'b0, 8'h14, 1, 2'd1, 0, 1, 0, 16'd0);
        tbl[5]  = mk(4'b0000, px(8'h00, 8'h00, 8'h00, 8'h00), 1'b0, 8'h14, 0, 2'd1, 0, 0, 0, 16'd0);
        tbl[6]  = mk(4'b0011, px(8'hA0, 8'hB0, 8'h00, 8'h00), 1'b0, 8'hA0, 1, 2'd0, 1, 0, 1, 16'd1);
        tbl[7]  = mk(4'b0010, px(8'h00, 8'hB1, 8'h00, 8'h00), 1'b1, 8'hA0, 0, 2'd0, 1, 0, 0, 16'd0);
        tbl[8]  = mk(4'b0010, px(8'h00, 8'hB2, 8'h00, 8'h00), 1'b0, 8'hA0, 0, 2'd0, 1, 0, 1, 16'd1);
        tbl[9]  = mk(4'b0010, px(8'h00, 8'hB3, 8'h00, 8'h00), 1'b0, 8'hA0, 0, 2'd0, 1, 0, 1, 16'd2);
        tbl[10] = mk(4'b0010, px(8'h00, 8'hB4, 8'h00, 8'h00), 1'b0, 8'hA0, 0, 2'd0, 1, 0, 1, 16'd3);
        tbl[11] = mk(4'b0011, px(8'hA1, 8'hB5, 8'h00, 8'h00), 1'b0, 8'hA1, 1, 2'd0, 1, 0, 1, 16'd4);
        tbl[12] = mk(4'b1101, px(8'hA2, 8'h00, 8'hC1, 8'hD1), 1'b0, 8'hA2, 1, 2'd0, 1, 0, 1, 16'd6);
        tbl[13] = mk(4'b0011, px(8'hA3, 8'hB6, 8'h00, 8'h00), 1'b0, 8'hA3, 1, 2'd0, 0, 1, 1, 16'd7);
        tbl[14] = mk(4'b0100, px(8'h00, 8'h00, 8'hC0, 8'h00), 1'b0, 8'hC0, 1, 2'd2, 1, 0, 1, 16'd7);
        tbl[15] = mk(4'b0000, px(8'h00, 8'h00, 8'h00, 8'h00), 1'b1, 8'hC0, 0, 2'd2, 1, 0, 0, 16'd0);

        rst = 1'b1; ch_en = '0; ch_pixel = '0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs(zero_v, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_vec(tbl[i], 100 + i);
        end

        // Mid-frame reset: second pixel of ch2's frame, then abort.
        run_vec(mk(4'b0100, px(8'h00, 8'h00, 8'hC1, 8'h00), 1'b0, 8'hC1, 1, 2'd2, 1, 0, 0, 16'd0), 200);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs(zero_v, 201);
        ch_en = '0;
        @(posedge clk);
        #1;
        chk_outputs(zero_v, 202);
        rst = 1'b0;
        // Counter restarted: frame_done only on the fourth pixel after reset.
        run_vec(mk(4'b0100, px(8'h00, 8'h00, 8'hD0, 8'h00), 1'b0, 8'hD0, 1, 2'd2, 1, 0, 0, 16'd0), 203);
        run_vec(mk(4'b0100, px(8'h00, 8'h00, 8'hD1, 8'h00), 1'b0, 8'hD1, 1, 2'd2, 1, 0, 0, 16'd0), 204);
        run_vec(mk(4'b0100, px(8'h00, 8'h00, 8'hD2, 8'h00), 1'b0, 8'hD2, 1, 2'd2, 1, 0, 0, 16'd0), 205);
        run_vec(mk(4'b0100, px(8'h00, 8'h00, 8'hD3, 8'h00), 1'b0, 8'hD3, 1, 2'd2, 0, 1, 0, 16'd0), 206);

        // Silent owner: released after 8 cycles only when the timeout is built in.
        run_vec(mk(4'b0001, px(8'hE0, 8'h00, 8'h00, 8'h00), 1'b0, 8'hE0, 1, 2'd0, 1, 0, 0, 16'd0), 300);
        for (int i = 1; i <= 10; i++) begin
            v = mk(4'b0000, 32'h0, 1'b0, 8'hE0, 0, 2'd0, 1'b1, 0, 0, 16'd0);
            if (to_en && i >= 8) v.e_busy = 1'b0;
            run_vec(v, 300 + i);
        end
        if (to_en)
            v = mk(4'b0010, px(8'h00, 8'hF0, 8'h00, 8'h00), 1'b0, 8'hF0, 1, 2'd1, 1, 0, 0, 16'd0);
        else
            v = mk(4'b0010, px(8'h00, 8'hF0, 8'h00, 8'h00), 1'b0, 8'hE0, 0, 2'd0, 1, 0, 1, 16'd1);
        run_vec(v, 311);

        // Saturation: all four enabled every cycle gives exactly three drops per cycle.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ch_en = 4'b1111;
        ch_pixel = px(8'h01, 8'h02, 8'h03, 8'h04);
        clr = 1'b0;
        for (int n = 1; n <= 21850; n++) begin
            @(posedge clk);
            #1;
            if (n == 1)     chk("drop_cnt_o", 400, 32'(drop_cnt_o), 32'd3);
            if (n == 21844) chk("drop_cnt_o", 401, 32'(drop_cnt_o), 32'd65532);
            if (n == 21845) chk("drop_cnt_o", 402, 32'(drop_cnt_o), 32'hFFFF);
            if (n == 21846) chk("drop_cnt_o", 403, 32'(drop_cnt_o), 32'hFFFF);
            if (n == 21850) begin
                chk("drop_cnt_o",  404, 32'(drop_cnt_o),  32'hFFFF);
                chk("collision_o", 405, 32'(collision_o), 32'd1);
                chk("owner_o",     406, 32'(owner_o),     32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_stream_arbiter.md
PIXEL_STREAM_ARBITER -- requirements
Module: pixel_stream_arbiter

Interface
REQ-001 Param NUM_CH, default 2, number of pixel source channels (2..8).
REQ-002 Param PIX_W, default 8, pixel width in bits.
REQ-003 Param FRAME_PIX, default 291600 (540x540), pixels per frame.
REQ-004 Param TIMEOUT_CYC, default 1024, idle cycles before lock release (used only with timeout feature).
REQ-005 clk  input  1  sole clock; one clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 ch_pixel_i  input  NUM_CH*PIX_W  channel k pixel at bits [k*PIX_W +: PIX_W].
REQ-008 ch_pixel_en_i  input  NUM_CH  per-channel pixel valid.
REQ-009 clear_i  input  1  clears collision flag and drop counter.
REQ-010 pixel_o  output  PIX_W  forwarded pixel.
REQ-011 pixel_en_o  output  1  forwarded pixel valid.
REQ-012 owner_o  output  $clog2(NUM_CH)  index of the locked channel.
REQ-013 busy_o  output  1  high while a channel holds the lock.
REQ-014 frame_done_o  output  1  one-cycle pulse with the last pixel of a frame.
REQ-015 collision_o  output  1  sticky: a non-owner asserted enable.
REQ-016 drop_cnt_o  output  16  saturating count of dropped non-owner pixels.

Function
REQ-017 FSM states IDLE and LOCK; all outputs registered, 1-cycle latency input to output.
REQ-018 IDLE: lowest-index channel with enable high claims lock; LOCK entered, owner latched, its pixel forwarded as frame pixel 0.
REQ-019 IDLE with simultaneous enables: lowest index wins, every other enabled channel counts as one drop and sets collision.
REQ-020 LOCK: owner enable forwards pixel and increments pixel counter; owner enable low gives pixel_en_o=0 and pixel_o holds last value.
REQ-021 LOCK: any non-owner enable is dropped; drop_cnt_o increments by the number of dropping channels that cycle, saturating at 16'hFFFF.
REQ-022 Owner pixel with counter = FRAME_PIX-1: forwarded, frame_done_o pulses on the same output cycle, counter clears, FSM returns to IDLE.
REQ-023 A new claim is evaluated on the cycle after frame end, never on the frame-end cycle; non-owner enables on that cycle are drops.
REQ-024 FRAME_PIX=1: every claimed pixel is a complete frame; FSM re-enters IDLE each time.
REQ-025 clear_i has priority: that cycle collision_o and drop_cnt_o go to 0, and drops in the same cycle are not counted.
REQ-026 busy_o=1 exactly while the FSM is in LOCK; owner_o holds last owner while in IDLE.

Reset
REQ-027 rst asserted at any time, including mid-frame, forces IDLE, counter 0, all outputs 0; no frame_done_o is produced for the aborted frame.
REQ-028 First claim is evaluated on the first rising edge after rst deassertion.

Configuration
REQ-029 Macro PIXMUX_TIMEOUT_EN defined: in LOCK, TIMEOUT_CYC consecutive cycles without owner enable return the FSM to IDLE, counter cleared, no frame_done_o pulse.
REQ-030 PIXMUX_TIMEOUT_EN undefined: the lock persists until frame end or reset, and no idle counter exists.

Structure
REQ-031 Package pixmux_pkg holds the state enum (IDLE, LOCK), drop counter width 16, and the default FRAME_PIX and TIMEOUT_CYC constants.
REQ-032 One sub-module pixmux_prio_enc: NUM_CH-bit lowest-index priority encoder returning index and valid.

Verification
REQ-033 FRAME_PIX=4; ch1 sends 4 pixels 0x11..0x14 -> output 0x11..0x14, 1 cycle late, owner_o=1, frame_done_o with 0x14, then busy_o=0.
REQ-034 ch0 and ch1 enable together in IDLE -> owner_o=0, collision_o=1, drop_cnt_o=1.
REQ-035 ch0 locked; ch1 sends 3 pixels -> ch1 pixels never appear, drop_cnt_o=3; clear_i pulsed with ch1 enable -> drop_cnt_o=0, collision_o=0.
REQ-036 rst asserted after 2 of 4 pixels -> all outputs 0 immediately, no frame_done_o; next claim restarts at pixel 0.
REQ-037 With PIXMUX_TIMEOUT_EN and TIMEOUT_CYC=8, owner silent 8 cycles -> busy_o=0, no frame_done_o; ch1 then claims lock.
REQ-038 Drop counter preloaded near the limit with sustained ch1 drops -> drop_cnt_o stays at 16'hFFFF.
